// File: rtl/player_motion.sv
// Frame-ticked player controller: walking with a step divider and clamped x, plus an optional jump.
// Define PLAYER_MOTION_JUMP_EN to compile in the JUMP_UP/FALL states and the height counter.

module player_motion #(
   parameter int X_MIN    = 0,
   parameter int X_MAX    = 1008,
   parameter int X_INIT   = 40,
   parameter int Y_GROUND = 700,
   parameter int STEP_DIV = 10,
   parameter int JUMP_H   = 64
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        tick,
   input  logic [6:0]  key_code,
   output logic [11:0] xpos,
   output logic [11:0] ypos,
   output logic        facing,
   output logic        airborne
);

   localparam int                STEP_W    = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
   localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(STEP_DIV - 1);
   localparam logic [11:0]       XMIN_C    = 12'(X_MIN);
   localparam logic [11:0]       XMAX_C    = 12'(X_MAX);
   localparam logic [11:0]       XINIT_C   = 12'(X_INIT);
   localparam logic [11:0]       YGND_C    = 12'(Y_GROUND);

   generate
      if (STEP_DIV < 1 || JUMP_H > Y_GROUND) begin : gBadParam
         $error("player_motion: STEP_DIV must be >= 1 and JUMP_H <= Y_GROUND");
      end
   endgenerate

   logic keyRight, keyLeft, keyHoriz, heldLastTick;

   assign keyRight = (key_code == 7'h44) || (key_code == 7'h64);
   assign keyLeft  = (key_code == 7'h41) || (key_code == 7'h61);
   assign keyHoriz = keyRight || keyLeft;

   logic [STEP_W-1:0] stepCnt_q, stepCnt_d;
   logic [11:0]       xpos_q, xpos_d;
   logic              facing_q, facing_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         stepCnt_q <= '0;
         xpos_q    <= XINIT_C;
         facing_q  <= 1'b1;
      end else begin
         stepCnt_q <= stepCnt_d;
         xpos_q    <= xpos_d;
         facing_q  <= facing_d;
      end
   end

   // facing_q doubles as the last decoded direction, so a reversal is held-last-tick with a different key.
   always_comb begin
      stepCnt_d = stepCnt_q;
      xpos_d    = xpos_q;
      facing_d  = facing_q;
      if (tick) begin
         if (!keyHoriz) begin
            stepCnt_d = '0;
         end else begin
            facing_d = keyRight;
            if (heldLastTick && (keyRight != facing_q)) begin
               stepCnt_d = '0;
            end else if (stepCnt_q == STEP_LAST) begin
               stepCnt_d = '0;
               if (keyRight && (xpos_q < XMAX_C)) begin
                  xpos_d = xpos_q + 12'd1;
               end else if (keyLeft && (xpos_q > XMIN_C)) begin
                  xpos_d = xpos_q - 12'd1;
               end
            end else begin
               stepCnt_d = stepCnt_q + 1'b1;
            end
         end
      end
   end

   assign xpos   = xpos_q;
   assign facing = facing_q;

`ifdef PLAYER_MOTION_JUMP_EN
   localparam logic [11:0] JUMP_H_C = 12'(JUMP_H);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WALK    = 2'd1,
      JUMP_UP = 2'd2,
      FALL    = 2'd3
   } state_e;

   state_e      state_q, state_d;
   logic        keyJump;
   logic [11:0] ypos_q, ypos_d;
   logic [11:0] heightCnt_q, heightCnt_d;
   logic        airborne_q, airborne_d;
   logic        heldPrev_q, heldPrev_d;

   assign keyJump = (key_code == 7'h57) || (key_code == 7'h77) || (key_code == 7'h20);

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         unique case (state_q)
            IDLE, WALK: begin
               if (keyJump) begin
                  state_d = (JUMP_H_C == 12'd1) ? FALL : JUMP_UP;
               end else if (keyHoriz) begin
                  state_d = WALK;
               end else begin
                  state_d = IDLE;
               end
            end
            JUMP_UP: if (heightCnt_q + 12'd1 == JUMP_H_C) state_d = FALL;
            FALL:    if (ypos_q + 12'd1 == YGND_C) state_d = IDLE;
            default: state_d = IDLE;
         endcase
      end
   end

   // The takeoff tick already rises one pixel, so the climb and the fall each take JUMP_H ticks.
   always_comb begin
      ypos_d      = ypos_q;
      heightCnt_d = heightCnt_q;
      heldPrev_d  = heldPrev_q;
      airborne_d  = (state_d == JUMP_UP) || (state_d == FALL);
      if (tick) begin
         heldPrev_d = keyHoriz;
         unique case (state_q)
            IDLE, WALK: begin
               if (keyJump) begin
                  ypos_d      = ypos_q - 12'd1;
                  heightCnt_d = 12'd1;
               end
            end
            JUMP_UP: begin
               ypos_d      = ypos_q - 12'd1;
               heightCnt_d = heightCnt_q + 12'd1;
            end
            FALL: begin
               ypos_d      = ypos_q + 12'd1;
               heightCnt_d = '0;
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         ypos_q      <= YGND_C;
         heightCnt_q <= '0;
         airborne_q  <= 1'b0;
         heldPrev_q  <= 1'b0;
      end else begin
         ypos_q      <= ypos_d;
         heightCnt_q <= heightCnt_d;
         airborne_q  <= airborne_d;
         heldPrev_q  <= heldPrev_d;
      end
   end

   assign heldLastTick = heldPrev_q;
   assign ypos         = ypos_q;
   assign airborne     = airborne_q;
`else
   typedef enum logic {
      IDLE = 1'b0,
      WALK = 1'b1
   } state_e;

   state_e state_q, state_d;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      if (tick) begin
         state_d = keyHoriz ? WALK : IDLE;
      end
   end

   always_comb begin
      heldLastTick = (state_q == WALK);
   end

   assign ypos     = YGND_C;
   assign airborne = 1'b0;
`endif

endmodule
